// File: rtl/sd_cmd_sequencer_pkg.sv
// Shared types and constants for the SD command sequencer and its CRC7 engine.
package sd_cmd_pkg;

  localparam int unsigned FRAME_W   = 48;
  localparam int unsigned PAYLOAD_W = 40;
  localparam int unsigned CRC_W     = 7;
  localparam int unsigned IDX_W     = 6;
  localparam int unsigned ARG_W     = 32;
  localparam int unsigned R1_W      = 8;
  localparam int unsigned POLL_W    = 8;
  localparam int unsigned BITCNT_W  = 6;

  localparam logic [CRC_W-1:0]   CRC7_POLY  = 7'h09;
  localparam logic [FRAME_W-1:0] POLL_FRAME = 48'hFFFF_FFFF_FFFF;
  localparam logic [1:0]         START_BITS = 2'b01;
  localparam logic               STOP_BIT   = 1'b1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CRC       = 3'd1;
  localparam state_t ST_LAUNCH    = 3'd2;
  localparam state_t ST_WAIT_CMD  = 3'd3;
  localparam state_t ST_POLL      = 3'd4;
  localparam state_t ST_WAIT_POLL = 3'd5;
  localparam state_t ST_CHECK     = 3'd6;
  localparam state_t ST_RESP      = 3'd7;

  typedef struct packed {
    logic [1:0]       start;
    logic [IDX_W-1:0] index;
    logic [ARG_W-1:0] arg;
    logic [CRC_W-1:0] crc;
    logic             stop;
  } sd_frame_t;

  // Precomputed CRC7 for the only commands that need a valid CRC in SPI mode.
  function automatic logic [CRC_W-1:0] crc7_const(input logic [IDX_W-1:0] idx);
    case (idx)
      6'd0:    crc7_const = 7'h4A;
      6'd8:    crc7_const = 7'h43;
      default: crc7_const = 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Boot-controller side of the SD command sequencer: command request and R1 response.
interface sd_cmd_sequencer_if;
  import sd_cmd_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [IDX_W-1:0] cmd_index;
  logic [ARG_W-1:0] cmd_arg;
  logic             resp_valid;
  logic [R1_W-1:0]  resp_r1;
  logic             resp_timeout;
  logic             busy;

  modport master (
    output cmd_valid, cmd_index, cmd_arg,
    input  cmd_ready, resp_valid, resp_r1, resp_timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg,
    output cmd_ready, resp_valid, resp_r1, resp_timeout, busy
  );

endinterface

// File: rtl/sd_cmd_sequencer_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB first, one bit per enabled cycle.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc,
  output logic [CRC_W-1:0] crc_next_c
);

  always_comb begin
    crc_next_c = crc;
    if (clr) begin
      crc_next_c = '0;
    end else if (en) begin
      crc_next_c = {crc[CRC_W-2:0], 1'b0} ^ (((din ^ crc[CRC_W-1]) == 1'b1) ? CRC7_POLY : 7'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc <= '0;
    else        crc <= crc_next_c;
  end

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD command sequencer: builds a 48-bit command frame, launches it, polls for R1.
// Optional macro SD_CMD_CRC_EN: serial CRC7 over the frame (40 extra cycles) instead of table CRC.
module sd_cmd_sequencer
  import sd_cmd_pkg::*;
#(
  parameter int unsigned POLL_MAX = 8,
  parameter logic [1:0]  CLK_DIV  = 2'b11,
  parameter logic        FBO      = 1'b1
) (
  input  logic                 spi_clk_i,
  input  logic                 spi_rst_i,
  sd_cmd_sequencer_if.slave    cmd,
  output logic                 spi_start_o,
  output logic                 spi_fbo_o,
  output logic [1:0]           clock_divider_o,
  output logic [FRAME_W-1:0]   transmission_data_o,
  input  logic                 spi_done_i,
  input  logic [FRAME_W-1:0]   received_data_i
);

  state_t              state_q, state_d;
  logic                done_q;
  logic                done_rise_c;
  logic                handshake_c;
  logic [POLL_W-1:0]   poll_q, poll_d;
  sd_frame_t           tx_q, tx_d;
  logic [FRAME_W-1:0]  rx_q, rx_d;
  logic [R1_W-1:0]     r1_q, r1_d;
  logic                to_q, to_d;
  logic                start_q, ready_q, busy_q, rvalid_q;
  logic                found_c;
  logic [R1_W-1:0]     scan_r1_c;

`ifdef SD_CMD_CRC_EN
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ARG_W-1:0]     arg_q, arg_d;
  logic [BITCNT_W-1:0]  bit_q, bit_d;
  logic                 crc_clr, crc_en, crc_bit;
  logic [CRC_W-1:0]     crc_q, crc_next_c;
  logic [PAYLOAD_W-1:0] payload_c;

  assign payload_c = {START_BITS, idx_q, arg_q};

  sd_crc7 u_crc7 (
    .clk        (spi_clk_i),
    .rst_n      (spi_rst_i),
    .clr        (crc_clr),
    .en         (crc_en),
    .din        (crc_bit),
    .crc        (crc_q),
    .crc_next_c (crc_next_c)
  );
`endif

  assign done_rise_c = spi_done_i & ~done_q;
  assign handshake_c = cmd.cmd_valid & ready_q;

  assign spi_fbo_o           = FBO;
  assign clock_divider_o     = CLK_DIV;
  assign spi_start_o         = start_q;
  assign transmission_data_o = tx_q;
  assign cmd.cmd_ready       = ready_q;
  assign cmd.busy            = busy_q;
  assign cmd.resp_valid      = rvalid_q;
  assign cmd.resp_r1         = r1_q;
  assign cmd.resp_timeout    = to_q;

  // R1 is the first byte, scanning from the MSB end, whose bit 7 is clear.
  always_comb begin
    found_c   = 1'b0;
    scan_r1_c = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      if (!found_c && !rx_q[FRAME_W-1-8*i]) begin
        found_c   = 1'b1;
        scan_r1_c = rx_q[FRAME_W-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    r1_d    = r1_q;
    to_d    = to_q;
`ifdef SD_CMD_CRC_EN
    idx_d   = idx_q;
    arg_d   = arg_q;
    bit_d   = bit_q;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_bit = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (handshake_c) begin
          poll_d = '0;
`ifdef SD_CMD_CRC_EN
          idx_d   = cmd.cmd_index;
          arg_d   = cmd.cmd_arg;
          bit_d   = '0;
          crc_clr = 1'b1;
          state_d = ST_CRC;
`else
          tx_d = '{start: START_BITS, index: cmd.cmd_index, arg: cmd.cmd_arg,
                   crc: crc7_const(cmd.cmd_index), stop: STOP_BIT};
          state_d = ST_LAUNCH;
`endif
        end
      end
`ifdef SD_CMD_CRC_EN
      ST_CRC: begin
        crc_en  = 1'b1;
        crc_bit = payload_c[6'd39 - bit_q];
        if (bit_q == 6'd39) begin
          // Last bit: the frame takes the CRC value being computed this cycle.
          tx_d = '{start: START_BITS, index: idx_q, arg: arg_q,
                   crc: crc_next_c, stop: STOP_BIT};
          state_d = ST_LAUNCH;
        end else begin
          bit_d = bit_q + 6'd1;
        end
      end
`endif
      ST_LAUNCH: state_d = ST_WAIT_CMD;
      ST_WAIT_CMD: begin
        if (done_rise_c) begin
          tx_d    = POLL_FRAME;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        poll_d  = poll_q + 8'd1;
        state_d = ST_WAIT_POLL;
      end
      ST_WAIT_POLL: begin
        if (done_rise_c) begin
          rx_d    = received_data_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (found_c) begin
          r1_d    = scan_r1_c;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else if (poll_q == POLL_W'(POLL_MAX)) begin
          r1_d    = 8'hFF;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      poll_q   <= '0;
      tx_q     <= POLL_FRAME;
      rx_q     <= POLL_FRAME;
      r1_q     <= 8'hFF;
      to_q     <= 1'b0;
      start_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= spi_done_i;
      poll_q   <= poll_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      r1_q     <= r1_d;
      to_q     <= to_d;
      start_q  <= (state_d == ST_LAUNCH) || (state_d == ST_POLL);
      ready_q  <= (state_d == ST_IDLE);
      busy_q   <= (state_d != ST_IDLE);
      rvalid_q <= (state_d == ST_RESP);
    end
  end

`ifdef SD_CMD_CRC_EN
  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      idx_q <= '0;
      arg_q <= '0;
      bit_q <= '0;
    end else begin
      idx_q <= idx_d;
      arg_q <= arg_d;
      bit_q <= bit_d;
    end
  end
`endif

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
Upstream command engine for the 48-bit SPI master in the SD-card boot path. It accepts an SD command (index and argument) and builds the 48-bit frame with CRC7. It launches the frame on the SPI master, then issues all-ones poll frames until an R1 response byte appears or the poll budget runs out. It returns R1 (or a timeout) to the boot controller.

Parameters:
POLL_MAX, 8, maximum number of poll frames after the command frame before timeout (1..255).
CLK_DIV, 2'b11, value driven on clock_divider_o (2'b11 = slowest, SD init speed).
FBO, 1'b1, value driven on spi_fbo_o (1 = MSB first).

Ports:
spi_clk_i  in  1  system clock, same clock as the SPI master; this block uses the rising edge.
spi_rst_i  in  1  reset, asynchronous, active-low.
cmd_valid_i  in  1  command request.
cmd_ready_o  out  1  high in IDLE only; a command is accepted when cmd_valid_i and cmd_ready_o are both high.
cmd_index_i  in  6  SD command index.
cmd_arg_i  in  32  SD command argument.
resp_valid_o  out  1  one-cycle pulse: resp_r1_o and resp_timeout_o are valid.
resp_r1_o  out  8  R1 byte; 8'hFF on timeout.
resp_timeout_o  out  1  no R1 found within POLL_MAX polls.
busy_o  out  1  high whenever not in IDLE.
spi_start_o  out  1  one-cycle start pulse to the SPI master.
spi_fbo_o  out  1  constant FBO.
clock_divider_o  out  2  constant CLK_DIV.
transmission_data_o  out  48  frame to the SPI master; held stable from launch until done.
spi_done_i  in  1  done level from the SPI master.
received_data_i  in  48  received frame from the SPI master; valid when spi_done_i rises.

Behaviour:
- Reset (spi_rst_i = 0, asynchronous) values:
  - state IDLE; cmd_ready_o 1; busy_o 0; spi_start_o 0; resp_valid_o 0; resp_timeout_o 0.
  - resp_r1_o 8'hFF; transmission_data_o 48'hFFFF_FFFF_FFFF; poll counter 0; done_q 0.
- Reset mid-operation aborts everything. No response pulse is produced.
- Frame layout: {2'b01, cmd_index, cmd_arg, crc7, 1'b1}.
  - CRC7 polynomial x^7+x^3+1, init 0, computed over frame bits [47:8], MSB first.
- Done edge detect: done_q registers spi_done_i; done_rise = spi_done_i & ~done_q.
- States and transitions:
  - IDLE: on handshake, latch index and arg, clear CRC and bit counter, go to CRC.
  - CRC: serial CRC, one bit per cycle for 40 cycles (bit counter 0..39). Then load transmission_data_o with the full frame and go to LAUNCH.
  - LAUNCH: spi_start_o = 1 for exactly this cycle; go to WAIT_CMD.
  - WAIT_CMD: on done_rise, discard received_data_i, load 48'hFFFF_FFFF_FFFF, go to POLL.
  - POLL: spi_start_o = 1 for one cycle; increment the poll counter; go to WAIT_POLL.
  - WAIT_POLL: on done_rise, capture received_data_i and go to CHECK.
  - CHECK: scan bytes [47:40], [39:32], … [7:0] in order. The first byte with bit7 == 0 is R1 → go to RESP.
    - No such byte and poll counter == POLL_MAX → resp_timeout_o = 1, R1 = 8'hFF, go to RESP.
    - Otherwise → go to POLL.
  - RESP: resp_valid_o = 1 for one cycle; go to IDLE.
- resp_r1_o and resp_timeout_o hold their values until the next RESP.
- Latency: handshake at cycle 0 → spi_start_o at cycle 41 (CRC on) or cycle 1 (CRC off).
- spi_done_i already high on entry to a WAIT state does not count as done_rise; only a 0→1 transition counts.
- cmd_valid_i is ignored while busy. No queueing.

Optional Feature:
SD_CMD_CRC_EN.
- Defined: serial CRC7 as described; the CRC state takes 40 cycles.
- Undefined: no CRC state; IDLE goes straight to LAUNCH. The CRC field is constant:
  - 7'h4A for index 0;
  - 7'h43 for index 8;
  - 7'h7F for all other indices.
  - Only CMD0 (arg 0) and CMD8 (arg 0x1AA) need a valid CRC in SPI mode.

Decomposition:
- Shared package sd_cmd_pkg holds:
  - state enum;
  - FRAME_W = 48;
  - CRC7_POLY = 7'h09;
  - POLL_FRAME = 48'hFFFF_FFFF_FFFF;
  - start/stop bit constants.
- One sub-module: sd_crc7, a serial CRC7 with clear, enable and bit input, plus a 7-bit output.

Test Plan:
- CMD0, arg 0 → transmission_data_o = 48'h40_0000_0000_95; spi_start_o at cycle 41. Model returns byte 8'h01 in byte [39:32] of the first poll → resp_r1_o = 8'h01, timeout 0.
- CMD8, arg 32'h0000_01AA → frame 48'h48_0000_01AA_87; R1 = 8'h01 in byte [47:40] → resp_r1_o = 8'h01.
- Model returns all 8'hFF for every poll, POLL_MAX = 8 → exactly 9 start pulses (1 command + 8 polls), resp_timeout_o = 1, resp_r1_o = 8'hFF.
- Async reset asserted in WAIT_POLL → outputs at reset values immediately, no resp_valid_o. A new CMD0 afterwards completes normally.
- cmd_valid_i held high through a whole transaction → exactly one command accepted; cmd_ready_o low from acceptance until the cycle after RESP.
- With SD_CMD_CRC_EN undefined, CMD17 arg 0 → frame 48'h51_0000_0000_FF, spi_start_o at cycle 1.
